// File: rtl/lasers_pkg.sv
// Shared constants and types for the laser-harp frame-buffer rectangle writer.
package lasers_pkg;

    localparam int unsigned H_RES  = 640;
    localparam int unsigned V_RES  = 480;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ADDR_W = 19;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } fb_state_e;

    typedef struct packed {
        logic [9:0]       x0;
        logic [8:0]       y0;
        logic [9:0]       w;
        logic [8:0]       h;
        logic             clear;
        logic [IDX_W-1:0] color;
    } fill_cmd_t;

    // y * 640 as (y << 9) + (y << 7), so no multiplier is needed.
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [8:0] y);
        return (ADDR_W'(y) << 9) + (ADDR_W'(y) << 7);
    endfunction

endpackage

// File: rtl/lasers_fb_addr_gen.sv
// Raster-order x/y walker for a clipped rectangle; yields the current pixel
// address incrementally and flags the final pixel.
module lasers_fb_addr_gen
    import lasers_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic [9:0]        i_x0,
    input  logic [8:0]        i_y0,
    input  logic [10:0]       i_x_end,
    input  logic [9:0]        i_y_end,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);

    logic [9:0]        r_x;
    logic [9:0]        r_x0;
    logic [8:0]        r_y;
    logic [10:0]       r_x_end;
    logic [9:0]        r_y_end;
    logic [ADDR_W-1:0] r_row_base;

    logic w_row_end;
    logic w_col_end;

    // Bounds are exclusive; compare against pos+1 to avoid underflow on end-1.
    assign w_row_end = ({1'b0, r_x} + 11'd1) == r_x_end;
    assign w_col_end = ({1'b0, r_y} + 10'd1) == r_y_end;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_x        <= '0;
            r_x0       <= '0;
            r_y        <= '0;
            r_x_end    <= '0;
            r_y_end    <= '0;
            r_row_base <= '0;
        end else if (i_load) begin
            r_x        <= i_x0;
            r_x0       <= i_x0;
            r_y        <= i_y0;
            r_x_end    <= i_x_end;
            r_y_end    <= i_y_end;
            r_row_base <= row_base_of(i_y0);
        end else if (i_step) begin
            if (w_row_end) begin
                r_x        <= r_x0;
                r_y        <= r_y + 9'd1;
                r_row_base <= r_row_base + ADDR_W'(H_RES);
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    assign o_addr = r_row_base + ADDR_W'(r_x);
    assign o_last = w_row_end && w_col_end;

endmodule

// File: rtl/lasers_fb_writer.sv
// Fills clipped rectangles of one palette index into the 640x480 indexed
// frame buffer, one pixel per clock, driving the RAM write port.
module lasers_fb_writer
    import lasers_pkg::*;
(
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [8:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic              cmd_clear,
    input  logic [IDX_W-1:0]  cmd_color,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [IDX_W-1:0]  wdata,
    output logic              busy,
    output logic              done
);

    fb_state_e         r_state;
    fb_state_e         w_state_next;
    fill_cmd_t         w_cmd;

    logic              w_accept;
    logic              w_empty;
    logic              w_last;
    logic [10:0]       w_x_sum;
    logic [9:0]        w_y_sum;
    logic [9:0]        w_x_start;
    logic [8:0]        w_y_start;
    logic [10:0]       w_x_end;
    logic [9:0]        w_y_end;
    logic [ADDR_W-1:0] w_addr;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [IDX_W-1:0]  r_wdata;
    logic              r_done;
    logic              w_we_d;
    logic [ADDR_W-1:0] w_waddr_d;
    logic [IDX_W-1:0]  w_wdata_d;
    logic              w_done_d;

    assign w_cmd = '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h,
                     clear: cmd_clear, color: cmd_color};

    assign w_accept = cmd_valid && cmd_ready;
    assign w_x_sum  = {1'b0, w_cmd.x0} + {1'b0, w_cmd.w};
    assign w_y_sum  = {1'b0, w_cmd.y0} + {1'b0, w_cmd.h};

    always_comb begin
        w_x_start = w_cmd.x0;
        w_y_start = w_cmd.y0;
        w_x_end   = (w_x_sum > 11'(H_RES)) ? 11'(H_RES) : w_x_sum;
        w_y_end   = (w_y_sum > 10'(V_RES)) ? 10'(V_RES) : w_y_sum;
        w_empty   = (w_cmd.w == '0) || (w_cmd.h == '0) ||
                    (w_cmd.x0 >= 10'(H_RES)) || (w_cmd.y0 >= 9'(V_RES));
        if (w_cmd.clear) begin
            w_x_start = '0;
            w_y_start = '0;
            w_x_end   = 11'(H_RES);
            w_y_end   = 10'(V_RES);
            w_empty   = 1'b0;
        end
    end

    lasers_fb_addr_gen u_addr_gen (
        .i_clk   (vga_clk),
        .i_rst_n (reset_n),
        .i_load  (w_accept && !w_empty),
        .i_step  (r_state == StFill),
        .i_x0    (w_x_start),
        .i_y0    (w_y_start),
        .i_x_end (w_x_end),
        .i_y_end (w_y_end),
        .o_addr  (w_addr),
        .o_last  (w_last)
    );

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (w_accept) w_state_next = w_empty ? StDone : StFill;
            StFill: if (w_last) w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_we_d    = 1'b0;
        w_waddr_d = r_waddr;
        w_wdata_d = r_wdata;
        w_done_d  = (r_state == StDone);
        if (r_state == StIdle && w_accept) begin
            w_wdata_d = w_cmd.color;
        end
        if (r_state == StFill) begin
            w_we_d    = 1'b1;
            w_waddr_d = w_addr;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_we    <= w_we_d;
            r_waddr <= w_waddr_d;
            r_wdata <= w_wdata_d;
            r_done  <= w_done_d;
        end
    end

    // Holding ready low during the done pulse enforces the 2-cycle command gap.
    assign cmd_ready = (r_state == StIdle) && !r_done;
    assign busy      = (r_state != StIdle);
    assign we        = r_we;
    assign waddr     = r_waddr;
    assign wdata     = r_wdata;
    assign done      = r_done;

endmodule

// File: tb/tb_lasers_fb_writer.sv
// Self-checking bench for lasers_fb_writer: table-driven rectangles with a
// write scoreboard, plus handshake and reset-abort sequences.
module tb_lasers_fb_writer;
    import lasers_pkg::*;

    logic              vga_clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x0;
    logic [8:0]        cmd_y0;
    logic [9:0]        cmd_w;
    logic [8:0]        cmd_h;
    logic              cmd_clear;
    logic [IDX_W-1:0]  cmd_color;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [IDX_W-1:0]  wdata;
    logic              busy;
    logic              done;

    lasers_fb_writer u_dut (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_clear (cmd_clear),
        .cmd_color (cmd_color),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] w;
        logic [8:0] h;
        logic       clr;
        logic [4:0] color;
        int         n;
    } vec_t;

    vec_t vecs [10];
    int   exp_q [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, req);
    endtask

    // Expected writes packed as {addr, data}, computed directly as y*640+x.
    task automatic push_model(input vec_t v);
        int xs, ys, xe, ye;
        if (v.clr) begin
            xs = 0; ys = 0; xe = 640; ye = 480;
        end else begin
            xs = int'(v.x0);
            ys = int'(v.y0);
            xe = xs + int'(v.w);
            ye = ys + int'(v.h);
            if (xe > 640) xe = 640;
            if (ye > 480) ye = 480;
        end
        for (int y = ys; y < ye; y++)
            for (int x = xs; x < xe; x++)
                exp_q.push_back((y * 640 + x) * 32 + int'(v.color));
    endtask

    task automatic drive(input vec_t v);
        cmd_x0    = v.x0;
        cmd_y0    = v.y0;
        cmd_w     = v.w;
        cmd_h     = v.h;
        cmd_clear = v.clr;
        cmd_color = v.color;
    endtask

    task automatic scramble();
        cmd_x0    = 10'($urandom);
        cmd_y0    = 9'($urandom);
        cmd_w     = 10'($urandom);
        cmd_h     = 9'($urandom);
        cmd_clear = 1'($urandom);
        cmd_color = 5'($urandom);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge vga_clk);
            t++;
        end
        chk("ready_wait", 32'(cmd_ready), 1);
    endtask

    task automatic check_write(input string nm);
        int e;
        if (exp_q.size() == 0) begin
            chk({nm, "_unexpected_wr_addr"}, 32'(waddr), -1);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_wr"}, 32'({waddr, wdata}), e);
        end
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_we"}, 32'(we), 0);
        chk({nm, "_waddr"}, 32'(waddr), 0);
        chk({nm, "_wdata"}, 32'(wdata), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_ready"}, 32'(cmd_ready), 1);
    endtask

    task automatic run_cmd(input string nm, input vec_t v);
        int idx = 0, nwr = 0, nbusy = 0, first = -1, done_at = -1;
        wait_ready();
        exp_q.delete();
        push_model(v);
        drive(v);
        cmd_valid = 1'b1;
        @(negedge vga_clk);
        cmd_valid = 1'b0;
        scramble();
        while (done_at < 0 && idx < v.n + 20) begin
            if (busy) nbusy++;
            if (we) begin
                if (first < 0) first = idx;
                nwr++;
                check_write(nm);
            end
            if (done) begin
                done_at = idx;
                chk({nm, "_ready_in_done"}, 32'(cmd_ready), 0);
                chk({nm, "_we_in_done"}, 32'(we), 0);
            end
            idx++;
            @(negedge vga_clk);
        end
        chk({nm, "_done_cycle"}, done_at, v.n + 1);
        chk({nm, "_wr_count"}, nwr, v.n);
        chk({nm, "_busy_cycles"}, nbusy, v.n + 1);
        if (v.n > 0) chk({nm, "_first_wr_cycle"}, first, 1);
        chk({nm, "_done_one_cycle"}, 32'(done), 0);
        chk({nm, "_ready_after"}, 32'(cmd_ready), 1);
        chk({nm, "_sb_empty"}, exp_q.size(), 0);
    endtask

    // Start a full-screen clear, check its leading writes, then abort with reset.
    task automatic clear_abort(input string nm, input logic [4:0] color, input int nchk);
        wait_ready();
        scramble();
        cmd_clear = 1'b1;
        cmd_color = color;
        cmd_valid = 1'b1;
        @(negedge vga_clk);
        cmd_valid = 1'b0;
        scramble();
        chk({nm, "_lat_we"}, 32'(we), 0);
        @(negedge vga_clk);
        for (int k = 0; k < nchk; k++) begin
            chk({nm, "_wr"}, 32'({we, waddr, wdata}), 32'({1'b1, 19'(k), color}));
            @(negedge vga_clk);
        end
        reset_n = 1'b0;
        @(negedge vga_clk);
        chk({nm, "_we_at_rst_edge"}, 32'(we), 0);
        repeat (2) @(negedge vga_clk);
        check_reset_vals({nm, "_rst"});
        reset_n = 1'b1;
        @(negedge vga_clk);
    endtask

    task automatic handshake();
        vec_t a, b;
        int idx = 0, nwr = 0, ndone = 0, phase = 0, done_a = -1, acc_b = -1;
        logic acc_pending = 1'b0;
        a = '{x0: 20, y0: 5, w: 4, h: 2, clr: 0, color: 12, n: 8};
        b = '{x0: 600, y0: 100, w: 50, h: 2, clr: 0, color: 5, n: 80};
        wait_ready();
        exp_q.delete();
        push_model(a);
        push_model(b);
        drive(a);
        cmd_valid = 1'b1;
        @(negedge vga_clk);
        while (ndone < 2 && idx < 300) begin
            if (acc_pending) begin
                cmd_valid   = 1'b0;
                acc_pending = 1'b0;
                scramble();
                phase = 2;
            end
            if (we) begin
                nwr++;
                check_write("hs");
            end
            if (phase == 0) begin
                chk("hs_ready_low", 32'(cmd_ready), 0);
                if (done) begin
                    ndone++;
                    done_a = idx;
                    drive(b);
                    phase = 1;
                end else begin
                    scramble();
                end
            end else if (phase == 1) begin
                if (cmd_ready) begin
                    acc_b       = idx;
                    acc_pending = 1'b1;
                end
            end else if (done) begin
                ndone++;
            end
            idx++;
            @(negedge vga_clk);
        end
        chk("hs_accept_gap", acc_b - done_a, 1);
        chk("hs_done_count", ndone, 2);
        chk("hs_wr_count", nwr, a.n + b.n);
        chk("hs_sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{x0: 10,  y0: 2,   w: 3,   h: 2, clr: 0, color: 7,  n: 6};
        vecs[1] = '{x0: 638, y0: 479, w: 5,   h: 4, clr: 0, color: 31, n: 2};
        vecs[2] = '{x0: 5,   y0: 5,   w: 0,   h: 3, clr: 0, color: 4,  n: 0};
        vecs[3] = '{x0: 700, y0: 10,  w: 4,   h: 4, clr: 0, color: 9,  n: 0};
        vecs[4] = '{x0: 20,  y0: 480, w: 4,   h: 4, clr: 0, color: 9,  n: 0};
        vecs[5] = '{x0: 0,   y0: 0,   w: 640, h: 1, clr: 0, color: 3,  n: 640};
        vecs[6] = '{x0: 630, y0: 10,  w: 20,  h: 3, clr: 0, color: 17, n: 30};
        vecs[7] = '{x0: 100, y0: 200, w: 1,   h: 1, clr: 0, color: 30, n: 1};
        vecs[8] = '{x0: 0,   y0: 477, w: 2,   h: 9, clr: 0, color: 11, n: 6};
        vecs[9] = '{x0: 5,   y0: 5,   w: 4,   h: 0, clr: 0, color: 2,  n: 0};

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        scramble();
        repeat (3) @(negedge vga_clk);
        check_reset_vals("init");
        reset_n = 1'b1;
        @(negedge vga_clk);

        clear_abort("clr0", 5'd0, 1500);

        for (int i = 0; i < 10; i++) run_cmd($sformatf("v%0d", i), vecs[i]);

        handshake();

        clear_abort("clr21", 5'd21, 700);
        run_cmd("post_rst", vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
